board_memory: RTL and testbench

Board storage and win-detection responder for the tic-tac-toe datapath. Accepts the game controller's cell writes (address plus cell state), stores the 3x3 board, and after every accepted move sequentially scans the eight winning lines. Drives `gameIsDone` and `winner` back to the controller, and exposes a read port and a flat board vector for the display logic.

---
 rtl/board_memory_if.sv | 23 ++
 rtl/board_memory.sv | 137 +++++++++++++
 tb/tb_board_memory.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/board_memory_if.sv
// Controller/display bus for the tic-tac-toe board store.
interface board_memory_if;
  logic [3:0]  addr;
  logic [1:0]  cellState;
  logic [3:0]  rdAddr;
  logic [1:0]  rdData;
  logic [17:0] board;
  logic        busy;
  logic        gameIsDone;
  logic [1:0]  winner;
  logic [3:0]  moveCount;
  logic        writeError;

  modport master (
    output addr, cellState, rdAddr,
    input  rdData, board, busy, gameIsDone, winner, moveCount, writeError
  );

  modport slave (
    input  addr, cellState, rdAddr,
    output rdData, board, busy, gameIsDone, winner, moveCount, writeError
  );
endinterface

// File: rtl/board_memory.sv
// Board storage for tic-tac-toe: accepts cell writes, then scans the eight
// winning lines one per cycle and latches the game result.
//
// state | meaning
// IDLE  | waiting for a cell write
// CHECK | scanning line line_q (0..7), one line per cycle
// DONE  | game finished (win or tie); terminal until reset
module board_memory (
  input logic           ph1,
  input logic           reset,
  board_memory_if.slave bus
);

  typedef enum logic [1:0] {IDLE, CHECK, DONE} state_t;

  state_t      state_q, state_n;
  logic [2:0]  line_q, line_n;
  logic [17:0] board_q, board_n;
  logic [3:0]  count_q, count_n;
  logic [1:0]  winner_q, winner_n;
  logic        err_q, err_n;

  logic [11:0] line_idx;
  logic [1:0]  ca, cb, cc;
  logic        line_win;
  logic        in_range;
  logic        accept;

  // Cell lookup; indices above 8 read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = 2'b00;
    for (int k = 0; k < 9; k++)
      if (idx == 4'(k)) r = b[2*k +: 2];
    return r;
  endfunction

  // Three cell indices of each winning line, packed as {a, b, c}.
  function automatic logic [11:0] line_cells(input logic [2:0] ln);
    logic [11:0] r;
    r = 12'h012;
    case (ln)
      3'd0: r = 12'h012;
      3'd1: r = 12'h345;
      3'd2: r = 12'h678;
      3'd3: r = 12'h036;
      3'd4: r = 12'h147;
      3'd5: r = 12'h258;
      3'd6: r = 12'h048;
      3'd7: r = 12'h246;
    endcase
    return r;
  endfunction

  // Line evaluation and write qualification for the current cycle.
  always_comb begin
    line_idx = line_cells(line_q);
    ca       = cell_at(board_q, line_idx[11:8]);
    cb       = cell_at(board_q, line_idx[7:4]);
    cc       = cell_at(board_q, line_idx[3:0]);
    line_win = (ca != 2'b00) && (ca == cb) && (cb == cc);
    in_range = (bus.addr <= 4'd8);
    accept   = in_range && bus.cellState[1] &&
               (cell_at(board_q, bus.addr) == 2'b00) && (state_q == IDLE);
  end

  // Next-state logic: write acceptance, line scan and result latch.
  always_comb begin
    state_n  = state_q;
    line_n   = line_q;
    board_n  = board_q;
    count_n  = count_q;
    winner_n = winner_q;
    err_n    = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          for (int k = 0; k < 9; k++)
            if (bus.addr == 4'(k)) board_n[2*k +: 2] = bus.cellState;
          count_n = count_q + 4'd1;
          line_n  = 3'd0;
          state_n = CHECK;
        end else if (in_range) begin
          err_n = 1'b1;
        end
      end
      CHECK: begin
        // Writes arriving mid-scan are dropped, not queued.
        err_n = in_range;
        if (line_win) begin
          winner_n = ca;
          state_n  = DONE;
        end else if (line_q == 3'd7) begin
          line_n = 3'd0;
          if (count_q == 4'd9) begin
            winner_n = 2'b01;
            state_n  = DONE;
          end else begin
            state_n = IDLE;
          end
        end else begin
          line_n = line_q + 3'd1;
        end
      end
      DONE: err_n = in_range;
      default: state_n = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge ph1 or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      line_q   <= 3'd0;
      board_q  <= 18'd0;
      count_q  <= 4'd0;
      winner_q <= 2'b00;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_n;
      line_q   <= line_n;
      board_q  <= board_n;
      count_q  <= count_n;
      winner_q <= winner_n;
      err_q    <= err_n;
    end
  end

  assign bus.rdData     = cell_at(board_q, bus.rdAddr);
  assign bus.board      = board_q;
  assign bus.busy       = (state_q == CHECK);
  assign bus.gameIsDone = (state_q == DONE);
  assign bus.winner     = winner_q;
  assign bus.moveCount  = count_q;
  assign bus.writeError = err_q;

endmodule

// File: tb/tb_board_memory.sv
// Scoreboard bench for board_memory: stimulus pushes expected events
// (write errors, scan completions); a negedge monitor pops and compares.
module tb_board_memory;

  logic ph1 = 1'b0;
  logic reset = 1'b1;

  board_memory_if bus ();

  board_memory dut (
    .ph1  (ph1),
    .reset(reset),
    .bus  (bus)
  );

  always #5 ph1 = ~ph1;

  localparam logic [1:0] O = 2'b11;
  localparam logic [1:0] X = 2'b10;

  typedef struct {
    bit          is_err;
    int          len;
    logic [1:0]  win;
    logic        done;
    logic [3:0]  cnt;
    logic [17:0] brd;
  } ev_t;

  ev_t exp_q[$];

  int pass_cnt  = 0;
  int total_cnt = 0;
  logic [17:0] exp_board = 18'd0;

  // Monitor state.
  bit prev_busy = 1'b0;
  int busy_len  = 0;

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic check_event(input bit is_err, input int len);
    ev_t e;
    total_cnt++;
    if (exp_q.size() == 0) begin
      $display("FAIL unexpected_event: got err=%0d len=%0d with nothing expected at %0t",
               is_err, len, $time);
      return;
    end
    e = exp_q.pop_front();
    if (e.is_err == is_err && (is_err || e.len == len) &&
        bus.winner == e.win && bus.gameIsDone == e.done &&
        bus.moveCount == e.cnt && bus.board == e.brd)
      pass_cnt++;
    else
      $display("FAIL event@%0t: got err=%0d len=%0d win=%b done=%b cnt=%0d board=%h; expected err=%0d len=%0d win=%b done=%b cnt=%0d board=%h",
               $time, is_err, len, bus.winner, bus.gameIsDone, bus.moveCount, bus.board,
               e.is_err, e.len, e.win, e.done, e.cnt, e.brd);
  endtask

  // Monitor: error pulses and scan completions, sampled away from the active edge.
  always @(negedge ph1) begin
    if (reset) begin
      prev_busy = 1'b0;
      busy_len  = 0;
    end else begin
      if (bus.writeError) check_event(1'b1, 0);
      if (bus.busy) busy_len++;
      if (prev_busy && !bus.busy) begin
        check_event(1'b0, busy_len);
        busy_len = 0;
      end
      prev_busy = bus.busy;
    end
  end

  task automatic push_scan(input int len, input logic [1:0] win, input logic done,
                           input logic [3:0] cnt);
    ev_t e;
    e.is_err = 1'b0; e.len = len; e.win = win; e.done = done; e.cnt = cnt; e.brd = exp_board;
    exp_q.push_back(e);
  endtask

  task automatic push_err(input logic [1:0] win, input logic done, input logic [3:0] cnt);
    ev_t e;
    e.is_err = 1'b1; e.len = 0; e.win = win; e.done = done; e.cnt = cnt; e.brd = exp_board;
    exp_q.push_back(e);
  endtask

  task automatic set_cell(input int k, input logic [1:0] v);
    exp_board[2*k +: 2] = v;
  endtask

  task automatic wr(input logic [3:0] a, input logic [1:0] s);
    @(posedge ph1); #1;
    bus.addr = a; bus.cellState = s;
    @(posedge ph1); #1;
    bus.addr = 4'hF; bus.cellState = 2'b00;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(posedge ph1); #1;
      n++;
    end
    if (bus.busy) begin
      total_cnt++;
      $display("FAIL scan_timeout: busy still %b after %0d cycles, expected 0", bus.busy, n);
    end
    @(negedge ph1); #1;
  endtask

  task automatic do_reset();
    @(posedge ph1); #1 reset = 1'b1;
    @(posedge ph1); #1 reset = 1'b0;
    exp_board = 18'd0;
  endtask

  // Accepted move that does not end the game.
  task automatic move(input int k, input logic [1:0] v, input logic [3:0] cnt);
    wr(4'(k), v);
    set_cell(k, v);
    push_scan(8, 2'b00, 1'b0, cnt);
    wait_idle();
  endtask

  initial begin
    bus.addr = 4'hF; bus.cellState = 2'b00; bus.rdAddr = 4'd4;
    repeat (2) @(posedge ph1);
    #1 reset = 1'b0;

    // Reset state.
    chk("rst_board", int'(bus.board), 0);
    chk("rst_count", int'(bus.moveCount), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_done", int'(bus.gameIsDone), 0);
    chk("rst_winner", int'(bus.winner), 0);
    chk("rst_err", int'(bus.writeError), 0);

    // Single move at the centre, then error cases.
    move(4, O, 4'd1);
    chk("rd_cell4", int'(bus.rdData), 3);
    wr(4'd4, X);                          // occupied
    push_err(2'b00, 1'b0, 4'd1);
    wr(4'd0, 2'b01);                      // illegal value
    push_err(2'b00, 1'b0, 4'd1);
    wr(4'd0, 2'b00);                      // empty value
    push_err(2'b00, 1'b0, 4'd1);
    wr(4'hF, O);                          // idle address: nothing
    wr(4'd12, O);                         // out of range: nothing
    repeat (2) @(posedge ph1); #1;
    chk("noop_board", int'(bus.board), int'(exp_board));
    chk("noop_count", int'(bus.moveCount), 1);
    bus.rdAddr = 4'd10; #1;
    chk("rd_oob", int'(bus.rdData), 0);
    bus.rdAddr = 4'd0;

    // Write during scan is dropped and flagged.
    wr(4'd0, X);
    set_cell(0, X);
    wr(4'd8, X);
    push_err(2'b00, 1'b0, 4'd2);
    push_scan(8, 2'b00, 1'b0, 4'd2);
    wait_idle();
    chk("rd_cell0", int'(bus.rdData), 2);

    // O wins on line 0.
    do_reset();
    move(0, O, 4'd1);
    move(1, O, 4'd2);
    wr(4'd2, O);
    set_cell(2, O);
    push_scan(1, 2'b11, 1'b1, 4'd3);
    wait_idle();
    wr(4'd5, X);
    push_err(2'b11, 1'b1, 4'd3);
    repeat (2) @(posedge ph1); #1;
    chk("done_cell5", int'(bus.board[11:10]), 0);

    // X wins on line 7 (anti-diagonal).
    do_reset();
    move(0, O, 4'd1);
    move(2, X, 4'd2);
    move(1, O, 4'd3);
    move(4, X, 4'd4);
    wr(4'd6, X);
    set_cell(6, X);
    push_scan(8, 2'b10, 1'b1, 4'd5);
    wait_idle();

    // Nine-move draw.
    do_reset();
    move(0, O, 4'd1);
    move(1, X, 4'd2);
    move(2, O, 4'd3);
    move(4, X, 4'd4);
    move(3, O, 4'd5);
    move(5, X, 4'd6);
    move(7, O, 4'd7);
    move(6, X, 4'd8);
    wr(4'd8, O);
    set_cell(8, O);
    push_scan(8, 2'b01, 1'b1, 4'd9);
    wait_idle();

    // Reset in the middle of a scan.
    do_reset();
    wr(4'd4, O);
    repeat (3) @(posedge ph1);
    #2 reset = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_board", int'(bus.board), 0);
    chk("abort_count", int'(bus.moveCount), 0);
    chk("abort_done", int'(bus.gameIsDone), 0);
    chk("abort_winner", int'(bus.winner), 0);
    @(posedge ph1); #1 reset = 1'b0;
    exp_board = 18'd0;
    move(0, X, 4'd1);

    repeat (4) @(posedge ph1); #1;
    chk("queue_empty", exp_q.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
